multicycle_maindec: RTL and testbench

MULTICYCLE_MAINDEC -- requirements
Module: multicycle_maindec

---
 rtl/multicycle_maindec.sv | 235 +++++++++++++++++++++++
 tb/tb_multicycle_maindec.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_maindec.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_maindec
//  Purpose  : Main control decoder for a multicycle RV32I-subset datapath.
//             Moore FSM sequencing fetch, decode, memory, ALU, branch, jump
//             and upper-immediate instructions. Unsupported opcodes park the
//             FSM in a TRAP state until reset.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    EXT_JALR   : 1 = decode jalr, 0 = jalr traps
//    EXT_UPPER  : 1 = decode lui/auipc, 0 = they trap
//    MEM_WAIT   : 1 = honour mem_ready, 0 = memory always ready
//  Ports
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    op[6:0]    in   opcode from the instruction register
//    mem_ready  in   memory access completes this cycle
//    pc_write   out  unconditional PC update
//    branch     out  conditional PC update (qualified with Zero)
//    adr_src    out  memory address select: 0 PC, 1 Result
//    mem_write  out  store strobe
//    ir_write   out  latch instruction and OldPC
//    reg_write  out  register file write
//    result_src out  00 ALUOut, 01 Data, 10 ALUResult
//    alu_src_a  out  00 PC, 01 OldPC, 10 rs1, 11 zero
//    alu_src_b  out  00 rs2, 01 imm, 10 constant 4
//    alu_op     out  00 add, 01 subtract/compare, 10 funct-decoded
//    imm_src    out  000 I, 001 S, 010 B, 011 J, 100 U
//    illegal    out  sticky unsupported-opcode flag
// ============================================================================
module multicycle_maindec #(
  parameter bit EXT_JALR  = 1'b1,
  parameter bit EXT_UPPER = 1'b1,
  parameter bit MEM_WAIT  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       illegal
);

  // Opcodes
  localparam logic [6:0] c_OP_LW    = 7'b0000011;
  localparam logic [6:0] c_OP_SW    = 7'b0100011;
  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_I     = 7'b0010011;
  localparam logic [6:0] c_OP_BEQ   = 7'b1100011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

  // State encoding; 4'd14 and 4'd15 are unreachable and recover to TRAP
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_UPPER    = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       w_mem_ready;

  // With MEM_WAIT disabled every memory access completes in one cycle
  assign w_mem_ready = MEM_WAIT ? mem_ready : 1'b1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = S_TRAP;
    case (r_state)
      S_FETCH:    w_next_state = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          c_OP_LW,
          c_OP_SW:    w_next_state = S_MEMADR;
          c_OP_R:     w_next_state = S_EXECR;
          c_OP_I:     w_next_state = S_EXECI;
          c_OP_BEQ:   w_next_state = S_BEQ;
          c_OP_JAL:   w_next_state = S_JAL;
          c_OP_JALR:  w_next_state = EXT_JALR ? S_JALR : S_TRAP;
          c_OP_LUI,
          c_OP_AUIPC: w_next_state = EXT_UPPER ? S_UPPER : S_TRAP;
          default:    w_next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next_state = (op == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next_state = w_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: w_next_state = w_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next_state = S_ALUWB;
      S_EXECI:    w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BEQ:      w_next_state = S_FETCH;
      // jalr computes its target first, then shares the link/PC-write path of jal
      S_JALR:     w_next_state = S_JAL;
      S_JAL:      w_next_state = S_ALUWB;
      S_UPPER:    w_next_state = S_ALUWB;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_TRAP;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (state-decoded; FETCH strobes follow mem_ready)
  // --------------------------------------------------------------------------
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = w_mem_ready;
        pc_write   = w_mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        // Strobe held for every wait cycle until the memory accepts it
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_UPPER: begin
        // lui adds the immediate to zero; auipc adds it to OldPC
        alu_src_a = (op == c_OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Immediate format follows the opcode in every state
  // --------------------------------------------------------------------------
  always_comb begin
    imm_src = 3'b000;
    case (op)
      c_OP_SW:    imm_src = 3'b001;
      c_OP_BEQ:   imm_src = 3'b010;
      c_OP_JAL:   imm_src = 3'b011;
      c_OP_LUI,
      c_OP_AUIPC: imm_src = 3'b100;
      default:    imm_src = 3'b000;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_maindec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_maindec
//  Purpose  : Directed, scoreboard-checked bench for multicycle_maindec.
//             DUT A uses default parameters; DUT B has jalr disabled and
//             ignores mem_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_maindec;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] RT    = 7'b0110011;
  localparam logic [6:0] IT    = 7'b0010011;
  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] BAD   = 7'b0000000;

  logic clk;
  logic rst_n, rst_b_n;
  logic [6:0] op, op_b;
  logic mem_ready, mem_ready_b;

  logic pcw_a, br_a, adr_a, mw_a, irw_a, rw_a, ill_a;
  logic [1:0] rs_a, sa_a, sb_a, aop_a;
  logic [2:0] imm_a;
  logic pcw_b, br_b, adr_b, mw_b, irw_b, rw_b, ill_b;
  logic [1:0] rs_b, sa_b, sb_b, aop_b;
  logic [2:0] imm_b;

  multicycle_maindec dut_a (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pcw_a), .branch(br_a), .adr_src(adr_a), .mem_write(mw_a),
    .ir_write(irw_a), .reg_write(rw_a), .result_src(rs_a),
    .alu_src_a(sa_a), .alu_src_b(sb_a), .alu_op(aop_a),
    .imm_src(imm_a), .illegal(ill_a)
  );

  multicycle_maindec #(.EXT_JALR(1'b0), .EXT_UPPER(1'b1), .MEM_WAIT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .op(op_b), .mem_ready(mem_ready_b),
    .pc_write(pcw_b), .branch(br_b), .adr_src(adr_b), .mem_write(mw_b),
    .ir_write(irw_b), .reg_write(rw_b), .result_src(rs_b),
    .alu_src_a(sa_b), .alu_src_b(sb_b), .alu_op(aop_b),
    .imm_src(imm_b), .illegal(ill_b)
  );

  // Packed view: {pc_write,branch,adr_src,mem_write,ir_write,reg_write,
  //               result_src,alu_src_a,alu_src_b,alu_op,imm_src,illegal}
  logic [17:0] act_a, act_b;
  assign act_a = {pcw_a, br_a, adr_a, mw_a, irw_a, rw_a, rs_a, sa_a, sb_a, aop_a, imm_a, ill_a};
  assign act_b = {pcw_b, br_b, adr_b, mw_b, irw_b, rw_b, rs_b, sa_b, sb_b, aop_b, imm_b, ill_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-output builders, one per state as described for that state
  function automatic logic [17:0] E(input logic pcw, input logic br, input logic adr,
                                    input logic mw, input logic irw, input logic rw,
                                    input logic [1:0] rs, input logic [1:0] a,
                                    input logic [1:0] b, input logic [1:0] aop,
                                    input logic [2:0] imm, input logic ill);
    return {pcw, br, adr, mw, irw, rw, rs, a, b, aop, imm, ill};
  endfunction
  function automatic logic [17:0] x_fetch(input logic mr, input logic [2:0] imm);
    return E(mr, 0, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] x_dec(input logic [2:0] imm);
    return E(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] x_memadr(input logic [2:0] imm);
    return E(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] x_memrd();
    return E(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [17:0] x_memwb();
    return E(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [17:0] x_memwr();
    return E(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0);
  endfunction
  function automatic logic [17:0] x_aluwb(input logic [2:0] imm);
    return E(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] x_jal(input logic [2:0] imm);
    return E(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] x_trap(input logic [2:0] imm);
    return E(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1);
  endfunction

  // Scoreboard queues
  logic [17:0] qa_exp[$];
  string       qa_name[$];
  logic [17:0] qb_exp[$];
  string       qb_name[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Drive one cycle of stimulus just after the rising edge and queue the
  // expected outputs for that cycle.
  task automatic step_a(input logic rst, input logic [6:0] o, input logic mr,
                        input logic [17:0] e, input string nm);
    @(posedge clk);
    #1;
    rst_n     = rst;
    op        = o;
    mem_ready = mr;
    qa_exp.push_back(e);
    qa_name.push_back(nm);
  endtask

  task automatic step_b(input logic rst, input logic [6:0] o, input logic mr,
                        input logic [17:0] e, input string nm);
    @(posedge clk);
    #1;
    rst_b_n     = rst;
    op_b        = o;
    mem_ready_b = mr;
    qb_exp.push_back(e);
    qb_name.push_back(nm);
  endtask

  // Monitor: compares on the falling edge whenever an expectation is pending
  always @(negedge clk) begin
    logic [17:0] e;
    string nm;
    if (qa_exp.size() > 0) begin
      e  = qa_exp.pop_front();
      nm = qa_name.pop_front();
      n_checks++;
      if (act_a !== e) begin
        n_fail++;
        $display("FAIL A.%s: got %b required %b", nm, act_a, e);
      end
    end
    if (qb_exp.size() > 0) begin
      e  = qb_exp.pop_front();
      nm = qb_name.pop_front();
      n_checks++;
      if (act_b !== e) begin
        n_fail++;
        $display("FAIL B.%s: got %b required %b", nm, act_b, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0; op = LW; mem_ready = 1'b1;
    rst_b_n = 1'b0; op_b = JALR; mem_ready_b = 1'b0;

    // Reset state
    step_a(0, LW, 1, x_fetch(1, 3'b000), "reset_fetch");
    // lw: 5 cycles
    step_a(1, LW, 1, x_fetch(1, 3'b000), "lw_fetch");
    step_a(1, LW, 1, x_dec(3'b000),      "lw_decode");
    step_a(1, LW, 1, x_memadr(3'b000),   "lw_memadr");
    step_a(1, LW, 1, x_memrd(),          "lw_memread");
    step_a(1, LW, 1, x_memwb(),          "lw_memwb");
    // sw with 3 wait cycles in MEMWRITE
    step_a(1, SW, 1, x_fetch(1, 3'b001), "sw_fetch");
    step_a(1, SW, 1, x_dec(3'b001),      "sw_decode");
    step_a(1, SW, 1, x_memadr(3'b001),   "sw_memadr");
    step_a(1, SW, 0, x_memwr(),          "sw_wait1");
    step_a(1, SW, 0, x_memwr(),          "sw_wait2");
    step_a(1, SW, 0, x_memwr(),          "sw_wait3");
    step_a(1, SW, 1, x_memwr(),          "sw_done");
    // R-type with one fetch wait
    step_a(1, RT, 0, x_fetch(0, 3'b000), "r_fetch_wait");
    step_a(1, RT, 1, x_fetch(1, 3'b000), "r_fetch");
    step_a(1, RT, 1, x_dec(3'b000),      "r_decode");
    step_a(1, RT, 1, E(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,0), "r_exec");
    step_a(1, RT, 1, x_aluwb(3'b000),    "r_aluwb");
    // I-type
    step_a(1, IT, 1, x_fetch(1, 3'b000), "i_fetch");
    step_a(1, IT, 1, x_dec(3'b000),      "i_decode");
    step_a(1, IT, 1, E(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,3'b000,0), "i_exec");
    step_a(1, IT, 1, x_aluwb(3'b000),    "i_aluwb");
    // lw with one MEMREAD wait
    step_a(1, LW, 1, x_fetch(1, 3'b000), "lw2_fetch");
    step_a(1, LW, 1, x_dec(3'b000),      "lw2_decode");
    step_a(1, LW, 1, x_memadr(3'b000),   "lw2_memadr");
    step_a(1, LW, 0, x_memrd(),          "lw2_memread_wait");
    step_a(1, LW, 1, x_memrd(),          "lw2_memread");
    step_a(1, LW, 1, x_memwb(),          "lw2_memwb");
    // beq: 3 cycles, then FETCH of the next instruction
    step_a(1, BEQ, 1, x_fetch(1, 3'b010), "beq_fetch");
    step_a(1, BEQ, 1, x_dec(3'b010),      "beq_decode");
    step_a(1, BEQ, 1, E(0,1,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0), "beq_exec");
    // jal
    step_a(1, JAL, 1, x_fetch(1, 3'b011), "jal_fetch_after_beq");
    step_a(1, JAL, 1, x_dec(3'b011),      "jal_decode");
    step_a(1, JAL, 1, x_jal(3'b011),      "jal_jal");
    step_a(1, JAL, 1, x_aluwb(3'b011),    "jal_aluwb");
    // jalr: JALR then JAL then ALUWB
    step_a(1, JALR, 1, x_fetch(1, 3'b000), "jalr_fetch");
    step_a(1, JALR, 1, x_dec(3'b000),      "jalr_decode");
    step_a(1, JALR, 1, E(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0), "jalr_jalr");
    step_a(1, JALR, 1, x_jal(3'b000),      "jalr_jal");
    step_a(1, JALR, 1, x_aluwb(3'b000),    "jalr_aluwb");
    // lui / auipc
    step_a(1, LUI, 1, x_fetch(1, 3'b100), "lui_fetch");
    step_a(1, LUI, 1, x_dec(3'b100),      "lui_decode");
    step_a(1, LUI, 1, E(0,0,0,0,0,0,2'b00,2'b11,2'b01,2'b00,3'b100,0), "lui_upper");
    step_a(1, LUI, 1, x_aluwb(3'b100),    "lui_aluwb");
    step_a(1, AUIPC, 1, x_fetch(1, 3'b100), "auipc_fetch");
    step_a(1, AUIPC, 1, x_dec(3'b100),      "auipc_decode");
    step_a(1, AUIPC, 1, E(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b100,0), "auipc_upper");
    step_a(1, AUIPC, 1, x_aluwb(3'b100),    "auipc_aluwb");
    // sw interrupted by reset while waiting in MEMWRITE
    step_a(1, SW, 1, x_fetch(1, 3'b001), "swr_fetch");
    step_a(1, SW, 1, x_dec(3'b001),      "swr_decode");
    step_a(1, SW, 1, x_memadr(3'b001),   "swr_memadr");
    step_a(1, SW, 0, x_memwr(),          "swr_memwrite");
    step_a(0, SW, 1, x_fetch(1, 3'b001), "rst_in_memwrite");
    // Unsupported opcode traps and holds until reset
    step_a(1, BAD, 1, x_fetch(1, 3'b000), "bad_fetch");
    step_a(1, BAD, 1, x_dec(3'b000),      "bad_decode");
    step_a(1, BAD, 1, x_trap(3'b000),     "bad_trap1");
    step_a(1, BAD, 0, x_trap(3'b000),     "bad_trap2");
    step_a(0, BAD, 1, x_fetch(1, 3'b000), "bad_trap_reset");

    // DUT B: jalr disabled, memory never waits
    step_b(0, JALR, 0, x_fetch(1, 3'b000), "b_reset");
    step_b(1, JALR, 0, x_fetch(1, 3'b000), "b_fetch_nowait");
    step_b(1, JALR, 0, x_dec(3'b000),      "b_jalr_decode");
    step_b(1, JALR, 0, x_trap(3'b000),     "b_trap1");
    step_b(1, JALR, 0, x_trap(3'b000),     "b_trap2");
    step_b(1, JALR, 0, x_trap(3'b000),     "b_trap3");
    step_b(0, JALR, 0, x_fetch(1, 3'b000), "b_trap_reset");
    step_b(1, SW, 0, x_fetch(1, 3'b001),   "b_sw_fetch");
    step_b(1, SW, 0, x_dec(3'b001),        "b_sw_decode");
    step_b(1, SW, 0, x_memadr(3'b001),     "b_sw_memadr");
    step_b(1, SW, 0, x_memwr(),            "b_sw_memwrite");
    step_b(1, SW, 0, x_fetch(1, 3'b001),   "b_sw_next_fetch");

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (qa_exp.size() != 0 || qb_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending %0d/%0d required 0/0", qa_exp.size(), qb_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
